// File: rtl/two_d_idct_if.sv
// Coefficient-in / pixel-out bundle for the 8x8 inverse DCT block.
interface two_d_idct_if #(
    parameter int unsigned COEF_W = 27,
    parameter int unsigned PIX_W  = 9
);
    logic signed [COEF_W-1:0] x [64];
    logic                     IN_START;
    logic signed [PIX_W-1:0]  y [64];
    logic                     OUT_XFC;
    logic                     BUSY;

    modport master (
        output x,
        output IN_START,
        input  y,
        input  OUT_XFC,
        input  BUSY
    );

    modport slave (
        input  x,
        input  IN_START,
        output y,
        output OUT_XFC,
        output BUSY
    );
endinterface

// File: rtl/two_d_idct.sv
// Separable 8x8 inverse DCT: one row per cycle, then one column per cycle,
// results written back in place into the intermediate buffer, then loaded
// into the output register in a single edge.
module two_d_idct #(
    parameter int unsigned COEF_W = 27,
    parameter int unsigned PIX_W  = 9
) (
    input  logic        clock,
    input  logic        reset,
    two_d_idct_if.slave bus
);
    localparam int unsigned AccW  = COEF_W + 12;
    localparam int unsigned MidW  = COEF_W + 4;
    localparam int unsigned Acc2W = MidW + 12;
    localparam int          PMaxI = (1 << (PIX_W - 1)) - 1;
    localparam int          PMinI = -(1 << (PIX_W - 1));

    localparam logic signed [AccW-1:0]  RndA = AccW'(128);
    localparam logic signed [Acc2W-1:0] RndC = Acc2W'(128);
    localparam logic signed [Acc2W-1:0] PMax = Acc2W'(PMaxI);
    localparam logic signed [Acc2W-1:0] PMin = Acc2W'(PMinI);

    // StCapture is never entered: the IDLE exit edge itself captures x.
    // It is decoded only so a corrupted state falls back to IDLE.
    typedef enum logic [2:0] {StIdle, StCapture, StRow, StCol, StDone} state_e;

    state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;

    logic signed [COEF_W-1:0] xq [64];
    logic signed [MidW-1:0]   tq [64];
    logic signed [PIX_W-1:0]  y_q [64];
    logic                     xfc_q;

    logic signed [MidW-1:0]   row_res [8];
    logic signed [MidW-1:0]   col_res [8];
    logic signed [AccW-1:0]   acc_r;
    logic signed [Acc2W-1:0]  acc_c;

    // 128*cos(m*pi/16) rounded, m = 0..8
    function automatic int cmag(input int m);
        case (m)
            0: return 128;
            1: return 126;
            2: return 118;
            3: return 106;
            4: return 91;
            5: return 71;
            6: return 49;
            7: return 25;
            default: return 0;
        endcase
    endfunction

    // T[k][n]: fold the angle (2n+1)k*pi/16 into the first quadrant
    function automatic int tcoef(input int k, input int n);
        int m;
        int mag;
        logic neg;
        m   = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m <= 8) begin
            mag = cmag(m);
        end else if (m <= 16) begin
            mag = cmag(16 - m);
            neg = 1'b1;
        end else if (m <= 24) begin
            mag = cmag(m - 16);
            neg = 1'b1;
        end else begin
            mag = cmag(32 - m);
        end
        if (k == 0) begin
            mag = 91;
        end
        return neg ? -mag : mag;
    endfunction

    // Sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: IDLE -> ROW0..7 -> COL0..7 -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (bus.IN_START) begin
                    state_d = StRow;
                    idx_d   = 3'd0;
                end
            end
            StRow: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = StCol;
                end
            end
            StCol: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Input capture; contents only matter after a capture edge
    always_ff @(posedge clock) begin
        if (state_q == StIdle && bus.IN_START) begin
            xq <= bus.x;
        end
    end

    // Row pass for row idx_q
    always_comb begin
        acc_r = '0;
        for (int n = 0; n < 8; n++) begin
            acc_r = '0;
            for (int k = 0; k < 8; k++) begin
                acc_r = acc_r + AccW'(xq[{idx_q, 3'(k)}]) * AccW'(tcoef(k, n));
            end
            acc_r      = (acc_r + RndA) >>> 8;
            row_res[n] = acc_r[MidW-1:0];
        end
    end

    // Column pass for column idx_q, saturated to the pixel range
    always_comb begin
        acc_c = '0;
        for (int n = 0; n < 8; n++) begin
            acc_c = '0;
            for (int k = 0; k < 8; k++) begin
                acc_c = acc_c + Acc2W'(tq[{3'(k), idx_q}]) * Acc2W'(tcoef(k, n));
            end
            acc_c = (acc_c + RndC) >>> 8;
            if (acc_c > PMax) begin
                acc_c = PMax;
            end else if (acc_c < PMin) begin
                acc_c = PMin;
            end
            col_res[n] = acc_c[MidW-1:0];
        end
    end

    // Intermediate buffer, output block and transfer pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                tq[i]  <= '0;
                y_q[i] <= '0;
            end
            xfc_q <= 1'b0;
        end else begin
            xfc_q <= 1'b0;
            case (state_q)
                StRow: begin
                    for (int n = 0; n < 8; n++) begin
                        tq[{idx_q, 3'(n)}] <= row_res[n];
                    end
                end
                // Column c is never read again, so overwrite it in place
                StCol: begin
                    for (int n = 0; n < 8; n++) begin
                        tq[{3'(n), idx_q}] <= col_res[n];
                    end
                end
                StDone: begin
                    for (int i = 0; i < 64; i++) begin
                        y_q[i] <= tq[i][PIX_W-1:0];
                    end
                    xfc_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.y       = y_q;
    assign bus.OUT_XFC = xfc_q;
    assign bus.BUSY    = (state_q != StIdle);
endmodule

// File: tb/tb_two_d_idct.sv
// Directed and random checks of the 8x8 inverse DCT block.
module tb_two_d_idct;
    localparam int unsigned COEF_W = 27;
    localparam int unsigned PIX_W  = 9;
    localparam int          NB     = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    two_d_idct_if #(.COEF_W(COEF_W), .PIX_W(PIX_W)) bus ();

    two_d_idct #(.COEF_W(COEF_W), .PIX_W(PIX_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string name;
        int    x0;
        int    exp_y;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int tm [8][8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_y(input string name, input int exp [64]);
        int bad;
        bad = -1;
        for (int i = 0; i < 64; i++) begin
            if (int'(bus.y[i]) != exp[i] && bad < 0) bad = i;
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: y[%0d] got %0d, expected %0d", name, bad,
                     int'(bus.y[bad]), exp[bad]);
        end
    endtask

    task automatic fill(input int v, output int a [64]);
        for (int i = 0; i < 64; i++) a[i] = v;
    endtask

    task automatic set_x(input int a [64]);
        for (int i = 0; i < 64; i++) bus.x[i] = COEF_W'(a[i]);
    endtask

    function automatic void build_t();
        real pi, ck, v;
        pi = 3.14159265358979323846;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                ck = (k == 0) ? $sqrt(0.125) : 0.5;
                v  = 256.0 * ck * $cos(real'((2 * n + 1) * k) * pi / 16.0);
                tm[k][n] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
            end
        end
    endfunction

    // Integer reference: row pass, floor-shift, column pass, floor-shift, clamp
    function automatic void model(input int a [64], output int o [64]);
        longint mid [64];
        longint acc;
        longint pmax, pmin;
        pmax = (longint'(1) << (PIX_W - 1)) - 1;
        pmin = -(longint'(1) << (PIX_W - 1));
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < 8; n++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += longint'(tm[k][n]) * longint'(a[8*r+k]);
                mid[8*r+n] = (acc + 128) >>> 8;
            end
        end
        for (int c = 0; c < 8; c++) begin
            for (int n = 0; n < 8; n++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += longint'(tm[k][n]) * mid[8*k+c];
                acc = (acc + 128) >>> 8;
                if (acc > pmax) acc = pmax;
                else if (acc < pmin) acc = pmin;
                o[8*n+c] = int'(acc);
            end
        end
    endfunction

    // One isolated block: latency, busy span, result, pulse width
    task automatic run_block(input string name, input int a [64], input int exp [64]);
        int lat, busy_n;
        @(negedge clock);
        set_x(a);
        bus.IN_START = 1'b1;
        @(posedge clock);
        #1;
        bus.IN_START = 1'b0;
        lat    = -1;
        busy_n = bus.BUSY ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.BUSY) busy_n++;
            if (bus.OUT_XFC) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, lat, 17);
        check({name, "_busy_cycles"}, busy_n, 17);
        check_y(name, exp);
        @(posedge clock);
        #1;
        check({name, "_xfc_width"}, int'(bus.OUT_XFC), 0);
    endtask

    initial begin
        vec_t tbl [6];
        int   a [64];
        int   e [64];
        int   z [64];
        int   blk [NB][64];
        int   pulses, lat, edges;

        build_t();
        fill(0, z);
        tbl[0] = '{"dc800",    800,  101};
        tbl[1] = '{"sat_pos",  3000, 255};
        tbl[2] = '{"sat_neg", -3000, -256};
        tbl[3] = '{"zero",     0,    0};
        tbl[4] = '{"dc_neg",  -800,  -101};
        tbl[5] = '{"dc_tiny",  1,    0};

        bus.IN_START = 1'b0;
        set_x(z);
        #12;
        check("rst_busy", int'(bus.BUSY), 0);
        check("rst_xfc", int'(bus.OUT_XFC), 0);
        check_y("rst_y", z);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_no_start_busy", int'(bus.BUSY), 0);

        for (int v = 0; v < 6; v++) begin
            fill(0, a);
            a[0] = tbl[v].x0;
            fill(tbl[v].exp_y, e);
            run_block(tbl[v].name, a, e);
        end

        // Second request at E5 with different data must be dropped
        fill(0, a);
        a[0] = 800;
        @(negedge clock);
        set_x(a);
        bus.IN_START = 1'b1;
        @(posedge clock);
        #1;
        bus.IN_START = 1'b0;
        pulses = 0;
        lat    = -1;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                a[0] = 3000;
                set_x(a);
                bus.IN_START = 1'b1;
            end
            @(posedge clock);
            #1;
            if (i == 5) bus.IN_START = 1'b0;
            if (bus.OUT_XFC) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check("busy_rej_pulses", pulses, 1);
        check("busy_rej_latency", lat, 17);
        fill(101, e);
        check_y("busy_rej_y", e);
        repeat (5) @(posedge clock);
        #1;
        check_y("y_hold", e);

        // Reset just before E9 aborts the block
        fill(0, a);
        a[0] = -3000;
        @(negedge clock);
        set_x(a);
        bus.IN_START = 1'b1;
        @(posedge clock);
        #1;
        bus.IN_START = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_xfc", int'(bus.OUT_XFC), 0);
        check("midrst_busy", int'(bus.BUSY), 0);
        check_y("midrst_y", z);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            if (bus.OUT_XFC) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        fill(0, a);
        a[0] = 800;
        fill(101, e);
        run_block("after_rst", a, e);

        // Back-to-back random blocks with IN_START held high
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < 64; i++) begin
                int r;
                r = int'($urandom);
                if (b == NB - 1) blk[b][i] = (r <<< 5) >>> 5;
                else blk[b][i] = int'($urandom_range(0, 4000)) - 2000;
            end
        end
        @(negedge clock);
        set_x(blk[0]);
        bus.IN_START = 1'b1;
        @(posedge clock);
        #1;
        set_x(blk[1]);
        edges = 0;
        for (int b = 0; b < NB; b++) begin
            lat = -1;
            for (int i = 0; i < 40; i++) begin
                @(posedge clock);
                #1;
                edges++;
                if (bus.OUT_XFC) begin
                    lat = edges;
                    break;
                end
            end
            check($sformatf("b2b_spacing_%0d", b), lat, (b == 0) ? 17 : 18);
            model(blk[b], e);
            check_y($sformatf("b2b_y_%0d", b), e);
            if (b + 1 < NB) begin
                @(posedge clock);
                #1;
                edges = 1;
                if (b + 2 < NB) set_x(blk[b+2]);
                else bus.IN_START = 1'b0;
            end else begin
                bus.IN_START = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
